// File: rtl/regfile_dump_reader.sv
// Sequential dump of a register file over one combinational read port.
// Each word is snapshotted in its own FETCH cycle and streamed out on a valid/ready port.
module regfile_dump_reader #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                handshake_c;

  assign handshake_c = valid_q && out_ready;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output logic; abort overrides every state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_d   = '0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          data_d  = rf_data;
          addr_d  = idx_q;
          last_d  = (idx_q == LAST_IDX);
          valid_d = 1'b1;
          state_d = ST_SEND;
        end
        ST_SEND: begin
          if (handshake_c) begin
            valid_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              last_d  = 1'b0;
              done_d  = 1'b1;
              idx_d   = '0;
              state_d = ST_IDLE;
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = ST_FETCH;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      endcase
    end
  end

  assign rf_addr   = idx_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dumps, backpressure, abort,
// ignored start pulses, mid-dump writes and asynchronous reset.
module tb_regfile_dump_reader;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] rf [NUM_REGS];

  int checks = 0;
  int errors = 0;
  bit aborted;

  regfile_dump_reader #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Register file model: register 0 hardwired to zero
  assign rf_data = (rf_addr == '0) ? '0 : rf[rf_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload;
    for (int i = 0; i < int'(NUM_REGS); i++)
      rf[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
  endtask

  function automatic logic [31:0] exp_word(input int i, input bit wr);
    if (i == 0) return 32'h0;
    if (wr && i == 25) return 32'hDEAD_BEEF;
    return 32'h1000_0000 + 32'(i);
  endfunction

  // One dump from start pulse to done (or abort); checks every valid cycle.
  task automatic dump(input int bp_addr, input int abort_addr, input bit poke,
                      input bit wr, input int exp_cyc, output bit was_aborted);
    int cyc;
    int nxt;
    int bp_cnt;
    bit hs;
    bit first_seen;
    was_aborted = 1'b0;
    nxt         = 0;
    bp_cnt      = 0;
    first_seen  = 1'b0;
    out_ready   = 1'b1;
    start       = 1'b1;
    tick;
    start = 1'b0;
    cyc   = 0;
    check_eq("busy_after_start", busy, 1);
    while (cyc < 400) begin
      if (done) begin
        check_eq("done_words", nxt, NUM_REGS);
        check_eq("done_cycles", cyc, exp_cyc);
        check_eq("done_busy", busy, 0);
        check_eq("done_valid", out_valid, 0);
        check_eq("done_last", out_last, 0);
        return;
      end
      if (out_valid) begin
        if (!first_seen) begin
          check_eq("first_word_latency", cyc, 1);
          first_seen = 1'b1;
        end
        check_eq("out_addr", out_addr, nxt);
        check_eq("rf_addr", rf_addr, nxt);
        check_eq("out_data", out_data, exp_word(nxt, wr));
        check_eq("out_last", out_last, (nxt == int'(NUM_REGS) - 1));
      end
      out_ready = 1'b1;
      if (out_valid && out_addr == bp_addr && bp_cnt < 5) begin
        out_ready = 1'b0;
        bp_cnt++;
      end
      if (poke && out_valid && (out_addr == 5'd3 || out_addr == 5'd20)) start = 1'b1;
      if (wr && out_valid && out_addr == 5'd10) begin
        rf[25] = 32'hDEAD_BEEF;
        rf[5]  = 32'h5555_5555;
      end
      abort = out_valid && (out_addr == abort_addr);
      hs    = out_valid && out_ready;
      tick;
      cyc++;
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        check_eq("abort_valid", out_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_last", out_last, 0);
        check_eq("abort_rf_addr", rf_addr, 0);
        repeat (3) begin
          check_eq("abort_no_done", done, 0);
          tick;
        end
        check_eq("abort_stays_idle", busy, 0);
        was_aborted = 1'b1;
        return;
      end
      if (hs) nxt++;
    end
    check_eq("dump_timeout_done", done, 1);
  endtask

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    preload();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rf_addr", rf_addr, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_addr", out_addr, 0);
    check_eq("rst_out_last", out_last, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick;
    check_eq("idle_after_rst", busy, 0);

    // Full dump with ready held high
    preload();
    dump(-1, -1, 1'b0, 1'b0, 64, aborted);
    // start during the done cycle is accepted
    start = 1'b1;
    tick;
    start = 1'b0;
    check_eq("done_one_cycle", done, 0);
    check_eq("start_on_done_cycle", busy, 1);
    // abort from FETCH
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check_eq("abort_fetch_busy", busy, 0);
    check_eq("abort_fetch_valid", out_valid, 0);
    check_eq("abort_fetch_done", done, 0);
    tick;

    // Backpressure at addr 7 for 5 cycles
    preload();
    dump(7, -1, 1'b0, 1'b0, 69, aborted);
    tick;

    // Abort coincident with the handshake of addr 12, then a clean restart
    preload();
    dump(-1, 12, 1'b0, 1'b0, 0, aborted);
    preload();
    dump(-1, -1, 1'b0, 1'b0, 64, aborted);
    tick;

    // start pulses mid-dump are ignored; exactly one done
    preload();
    dump(-1, -1, 1'b1, 1'b0, 64, aborted);
    repeat (3) begin
      tick;
      check_eq("single_done", done, 0);
      check_eq("idle_after_dump", busy, 0);
    end

    // Writes during the dump: later word sees it, earlier word does not
    preload();
    dump(-1, -1, 1'b0, 1'b1, 64, aborted);
    tick;

    // Asynchronous reset between edges while in SEND
    preload();
    out_ready = 1'b0;
    start     = 1'b1;
    tick;
    start = 1'b0;
    tick;
    check_eq("pre_rst_valid", out_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", out_valid, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_done", done, 0);
    check_eq("async_rst_rf_addr", rf_addr, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      tick;
      check_eq("idle_after_async_rst", busy, 0);
      check_eq("no_valid_after_async_rst", out_valid, 0);
      check_eq("no_done_after_async_rst", done, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
